// File: rtl/taxi_dma_ram_if.sv
// Segmented DMA RAM read interface shared by DMA clients and RAMs.
interface taxi_dma_ram_if #(
  parameter int unsigned SEG_COUNT  = 1,
  parameter int unsigned SEG_DATA_W = 64,
  parameter int unsigned SEG_ADDR_W = 8
) ();
  logic [SEG_COUNT-1:0][SEG_ADDR_W-1:0] cmd_addr;
  logic [SEG_COUNT-1:0]                 cmd_valid;
  logic [SEG_COUNT-1:0]                 cmd_ready;
  logic [SEG_COUNT-1:0][SEG_DATA_W-1:0] resp_data;
  logic [SEG_COUNT-1:0]                 resp_valid;
  logic [SEG_COUNT-1:0]                 resp_ready;

  modport rd_mst (
    output cmd_addr, cmd_valid,
    input  cmd_ready,
    input  resp_data, resp_valid,
    output resp_ready
  );

  modport rd_slv (
    input  cmd_addr, cmd_valid,
    output cmd_ready,
    output resp_data, resp_valid,
    input  resp_ready
  );
endinterface

// File: rtl/taxi_dma_ram_mux_rd_fifo.sv
// In-order tracking FIFO holding the issuing port index of each outstanding read.
module taxi_dma_ram_mux_rd_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head_c
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;

  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + 1'b1;
    end else if (!push && pop) begin
      count_nxt = count - 1'b1;
    end
  end

  // Full/empty are registered from the next count so they are flop outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == CNT_W'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head_c = mem[rd_ptr];
endmodule

// File: rtl/taxi_dma_ram_mux_rd.sv
// Read-side DMA RAM mux: PORTS clients share one segmented RAM read interface.
// Define TAXI_DMA_RAM_MUX_RD_PRIORITY_EN for fixed priority (lowest port wins) instead of round-robin.
module taxi_dma_ram_mux_rd #(
  parameter int unsigned PORTS      = 2,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  taxi_dma_ram_if.rd_slv dma_ram_rd [PORTS],
  taxi_dma_ram_if.rd_mst ram_rd
);
  localparam int unsigned SEG_COUNT = ram_rd.SEG_COUNT;
  localparam int unsigned ADDR_W    = ram_rd.SEG_ADDR_W;
  localparam int unsigned SEL_W     = (PORTS > 1) ? $clog2(PORTS) : 1;

  logic [SEG_COUNT-1:0]             cli_cmd_valid    [PORTS];
  logic [SEG_COUNT-1:0][ADDR_W-1:0] cli_cmd_addr     [PORTS];
  logic [SEG_COUNT-1:0]             cli_resp_ready   [PORTS];
  logic [SEG_COUNT-1:0]             cli_cmd_ready_c  [PORTS];
  logic [SEG_COUNT-1:0]             cli_resp_valid_c [PORTS];

  logic [SEG_COUNT-1:0]             ram_cmd_valid;
  logic [SEG_COUNT-1:0][ADDR_W-1:0] ram_cmd_addr;
  logic [SEG_COUNT-1:0]             ram_resp_ready_c;

  // Flatten the interface array so ports can be selected by a run-time index.
  for (genvar p = 0; p < PORTS; p++) begin : g_port
    assign cli_cmd_valid[p]         = dma_ram_rd[p].cmd_valid;
    assign cli_cmd_addr[p]          = dma_ram_rd[p].cmd_addr;
    assign cli_resp_ready[p]        = dma_ram_rd[p].resp_ready;
    assign dma_ram_rd[p].cmd_ready  = cli_cmd_ready_c[p];
    assign dma_ram_rd[p].resp_valid = cli_resp_valid_c[p];
    assign dma_ram_rd[p].resp_data  = ram_rd.resp_data;
  end

  assign ram_rd.cmd_valid  = ram_cmd_valid;
  assign ram_rd.cmd_addr   = ram_cmd_addr;
  assign ram_rd.resp_ready = ram_resp_ready_c;

  for (genvar s = 0; s < SEG_COUNT; s++) begin : g_seg
    logic              grant_vld_c;
    logic [SEL_W-1:0]  grant_idx_c;
    logic              accept_c;
    logic              pop_c;
    logic              stage_valid;
    logic [ADDR_W-1:0] stage_addr;
    logic              fifo_full;
    logic              fifo_empty;
    logic [SEL_W-1:0]  head_c;

`ifdef TAXI_DMA_RAM_MUX_RD_PRIORITY_EN
    always_comb begin
      grant_vld_c = 1'b0;
      grant_idx_c = '0;
      for (int unsigned i = 0; i < PORTS; i++) begin
        if (!grant_vld_c && cli_cmd_valid[i][s]) begin
          grant_vld_c = 1'b1;
          grant_idx_c = SEL_W'(i);
        end
      end
    end
`else
    logic [SEL_W-1:0] rr_ptr;
    int unsigned      cand;

    // Search starts at the port after the last accepted grant.
    always_comb begin
      grant_vld_c = 1'b0;
      grant_idx_c = '0;
      cand        = 0;
      for (int unsigned i = 0; i < PORTS; i++) begin
        cand = (32'(rr_ptr) + i) % PORTS;
        if (!grant_vld_c && cli_cmd_valid[cand][s]) begin
          grant_vld_c = 1'b1;
          grant_idx_c = SEL_W'(cand);
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rr_ptr <= '0;
      end else if (accept_c) begin
        rr_ptr <= (grant_idx_c == SEL_W'(PORTS - 1)) ? '0 : grant_idx_c + 1'b1;
      end
    end
`endif

    // Full is sampled before any same-cycle pop, so a pop never frees a slot early.
    assign accept_c = !rst && grant_vld_c && !fifo_full &&
                      (!stage_valid || ram_rd.cmd_ready[s]);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stage_valid <= 1'b0;
        stage_addr  <= '0;
      end else if (!stage_valid || ram_rd.cmd_ready[s]) begin
        stage_valid <= accept_c;
        if (accept_c) stage_addr <= cli_cmd_addr[grant_idx_c][s];
      end
    end

    assign ram_resp_ready_c[s] = !fifo_empty && cli_resp_ready[head_c][s];
    assign pop_c               = ram_rd.resp_valid[s] && ram_resp_ready_c[s];
    assign ram_cmd_valid[s]    = stage_valid;
    assign ram_cmd_addr[s]     = stage_addr;

    taxi_dma_ram_mux_rd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (SEL_W)
    ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .push   (accept_c),
      .pop    (pop_c),
      .din    (grant_idx_c),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .head_c (head_c)
    );

    for (genvar p = 0; p < PORTS; p++) begin : g_route
      assign cli_cmd_ready_c[p][s]  = accept_c && (grant_idx_c == SEL_W'(p));
      assign cli_resp_valid_c[p][s] = ram_rd.resp_valid[s] && !fifo_empty &&
                                      (head_c == SEL_W'(p));
    end
  end
endmodule

// File: tb/tb_taxi_dma_ram_mux_rd.sv
// Self-checking bench for taxi_dma_ram_mux_rd: RAM model plus response scoreboard.
module tb_taxi_dma_ram_mux_rd;
  localparam int unsigned PORTS = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 8;

  typedef struct {
    int           port;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  taxi_dma_ram_if #(.SEG_COUNT(1), .SEG_DATA_W(DW), .SEG_ADDR_W(AW)) cli [PORTS] ();
  taxi_dma_ram_if #(.SEG_COUNT(1), .SEG_DATA_W(DW), .SEG_ADDR_W(AW)) ram ();

  logic          c_valid  [PORTS];
  logic [AW-1:0] c_addr   [PORTS];
  logic          c_rready [PORTS];
  logic          o_cready [PORTS];
  logic          o_rvalid [PORTS];
  logic [DW-1:0] o_rdata  [PORTS];

  for (genvar p = 0; p < PORTS; p++) begin : g_cli
    assign cli[p].cmd_valid  = c_valid[p];
    assign cli[p].cmd_addr   = c_addr[p];
    assign cli[p].resp_ready = c_rready[p];
    assign o_cready[p]       = cli[p].cmd_ready[0];
    assign o_rvalid[p]       = cli[p].resp_valid[0];
    assign o_rdata[p]        = cli[p].resp_data[0];
  end

  logic          ram_cready = 1'b1;
  logic          ram_resp_en = 1'b1;
  logic [AW-1:0] pend_q [$];
  int            pend_cnt = 0;
  logic [DW-1:0] pend_head = '0;

  assign ram.cmd_ready  = ram_cready;
  assign ram.resp_valid = ram_resp_en && (pend_cnt != 0);
  assign ram.resp_data  = pend_head;

  taxi_dma_ram_mux_rd #(.PORTS(PORTS), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .dma_ram_rd (cli),
    .ram_rd     (ram)
  );

  exp_t exp_q [$];
  int   checks = 0;
  int   errors = 0;
  int   deliv [PORTS];

  function automatic logic [DW-1:0] rdata(input logic [AW-1:0] a);
    return a + 8'h65;
  endfunction

  // RAM model: in-order, responds with rdata(addr) whenever enabled.
  always begin : ram_model
    logic          cmd_hs;
    logic          resp_hs;
    logic [AW-1:0] cmd_a;
    @(negedge clk);
    cmd_hs  = !rst && ram.cmd_valid[0] && ram_cready;
    cmd_a   = ram.cmd_addr[0];
    resp_hs = !rst && ram.resp_valid[0] && ram.resp_ready[0];
    @(posedge clk);
    #1;
    if (rst) begin
      pend_q.delete();
    end else begin
      if (resp_hs && pend_q.size() != 0) void'(pend_q.pop_front());
      if (cmd_hs) pend_q.push_back(cmd_a);
    end
    pend_cnt  = pend_q.size();
    pend_head = (pend_cnt != 0) ? rdata(pend_q[0]) : '0;
  end

  // Scoreboard: every client response must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst) begin
      for (int p = 0; p < PORTS; p++) begin
        if (o_rvalid[p]) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL resp_unexpected: port %0d data %h, required no response", p, o_rdata[p]);
          end else if (exp_q[0].port != p || o_rdata[p] !== exp_q[0].data) begin
            checks++;
            errors++;
            $display("FAIL resp_route: port %0d data %h, required port %0d data %h",
                     p, o_rdata[p], exp_q[0].port, exp_q[0].data);
            if (c_rready[p]) void'(exp_q.pop_front());
          end else if (c_rready[p]) begin
            checks++;
            deliv[p]++;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || pend_cnt != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d responses outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    for (int p = 0; p < PORTS; p++) begin
      c_valid[p] = 1'b1;
      c_addr[p] = '0;
      c_rready[p] = 1'b1;
      deliv[p] = 0;
    end
    repeat (2) @(negedge clk);
    checks += 2;
    if (ram.cmd_valid[0] !== 1'b0) begin errors++; $display("FAIL reset_ram_cmd_valid: got %b, required 0", ram.cmd_valid[0]); end
    if (ram.resp_ready[0] !== 1'b0) begin errors++; $display("FAIL reset_ram_resp_ready: got %b, required 0", ram.resp_ready[0]); end
    for (int p = 0; p < PORTS; p++) begin
      checks += 2;
      if (o_cready[p] !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready%0d: got %b, required 0", p, o_cready[p]); end
      if (o_rvalid[p] !== 1'b0) begin errors++; $display("FAIL reset_resp_valid%0d: got %b, required 0", p, o_rvalid[p]); end
    end
    for (int p = 0; p < PORTS; p++) c_valid[p] = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    step();
    c_valid[1] = 1'b1;
    c_addr[1] = 8'h40;
    @(negedge clk);
    checks += 2;
    if (o_cready[1] !== 1'b1) begin errors++; $display("FAIL single_cmd_ready1: got %b, required 1", o_cready[1]); end
    if (o_cready[0] !== 1'b0) begin errors++; $display("FAIL single_cmd_ready0: got %b, required 0", o_cready[0]); end
    if (o_cready[1]) exp_q.push_back('{port: 1, data: 8'hA5});
    step();
    c_valid[1] = 1'b0;
    @(negedge clk);
    checks += 2;
    if (ram.cmd_valid[0] !== 1'b1) begin errors++; $display("FAIL single_ram_cmd_valid: got %b, required 1", ram.cmd_valid[0]); end
    if (ram.cmd_addr[0] !== 8'h40) begin errors++; $display("FAIL single_ram_cmd_addr: got %h, required 40", ram.cmd_addr[0]); end
    wait_drain("single");
    @(negedge clk);
    checks += 3;
    if (ram.resp_ready[0] !== 1'b0) begin errors++; $display("FAIL single_empty_resp_ready: got %b, required 0", ram.resp_ready[0]); end
    if (deliv[1] != 1) begin errors++; $display("FAIL single_deliv1: got %0d, required 1", deliv[1]); end
    if (deliv[0] != 0) begin errors++; $display("FAIL single_deliv0: got %0d, required 0", deliv[0]); end
  endtask

  task automatic test_round_robin();
    int g [PORTS];
    int gp;
    int exp_gp;
    for (int p = 0; p < PORTS; p++) g[p] = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      for (int p = 0; p < PORTS; p++) begin
        c_valid[p] = 1'b1;
        c_addr[p] = AW'(i * 16 + p);
      end
      @(negedge clk);
      if (o_cready[0] && !o_cready[1]) gp = 0;
      else if (o_cready[1] && !o_cready[0]) gp = 1;
      else gp = -1;
`ifdef TAXI_DMA_RAM_MUX_RD_PRIORITY_EN
      exp_gp = 0;
`else
      exp_gp = i % 2;
`endif
      checks++;
      if (gp != exp_gp) begin errors++; $display("FAIL rr_grant%0d: got port %0d, required port %0d", i, gp, exp_gp); end
      if (gp >= 0) begin
        g[gp]++;
        exp_q.push_back('{port: gp, data: rdata(c_addr[gp])});
      end
    end
    step();
    for (int p = 0; p < PORTS; p++) c_valid[p] = 1'b0;
`ifdef TAXI_DMA_RAM_MUX_RD_PRIORITY_EN
    exp_gp = 8;
`else
    exp_gp = 4;
`endif
    checks++;
    if (g[0] != exp_gp || g[0] + g[1] != 8) begin
      errors++;
      $display("FAIL rr_totals: got %0d/%0d, required %0d/%0d", g[0], g[1], exp_gp, 8 - exp_gp);
    end
    wait_drain("rr");
  endtask

  task automatic test_in_order();
    int            ports [3];
    logic [AW-1:0] addrs [3];
    ports = '{0, 1, 0};
    addrs = '{8'h00, 8'h10, 8'h20};
    for (int p = 0; p < PORTS; p++) deliv[p] = 0;
    ram_resp_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      for (int p = 0; p < PORTS; p++) c_valid[p] = 1'b0;
      c_valid[ports[k]] = 1'b1;
      c_addr[ports[k]] = addrs[k];
      @(negedge clk);
      checks++;
      if (o_cready[ports[k]] !== 1'b1) begin errors++; $display("FAIL order_cmd_ready%0d: got %b, required 1", k, o_cready[ports[k]]); end
      else exp_q.push_back('{port: ports[k], data: rdata(addrs[k])});
    end
    step();
    for (int p = 0; p < PORTS; p++) c_valid[p] = 1'b0;
    step();
    ram_resp_en = 1'b1;
    wait_drain("order");
    checks += 2;
    if (deliv[0] != 2) begin errors++; $display("FAIL order_deliv0: got %0d, required 2", deliv[0]); end
    if (deliv[1] != 1) begin errors++; $display("FAIL order_deliv1: got %0d, required 1", deliv[1]); end
  endtask

  task automatic test_fifo_full();
    ram_resp_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      c_valid[0] = 1'b1;
      c_addr[0] = AW'(8'h30 + k);
      @(negedge clk);
      checks++;
      if (o_cready[0] !== 1'b1) begin errors++; $display("FAIL full_fill%0d: got %b, required 1", k, o_cready[0]); end
      else exp_q.push_back('{port: 0, data: rdata(c_addr[0])});
    end
    step();
    c_addr[0] = 8'h34;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checks++;
      if (o_cready[0] !== 1'b0) begin errors++; $display("FAIL full_block%0d: got %b, required 0", j, o_cready[0]); end
      step();
    end
    ram_resp_en = 1'b1;
    @(negedge clk);
    checks += 2;
    if (ram.resp_ready[0] !== 1'b1) begin errors++; $display("FAIL full_pop_ready: got %b, required 1", ram.resp_ready[0]); end
    if (o_cready[0] !== 1'b0) begin errors++; $display("FAIL full_pop_cycle: got %b, required 0", o_cready[0]); end
    step();
    @(negedge clk);
    checks++;
    if (o_cready[0] !== 1'b1) begin errors++; $display("FAIL full_after_pop: got %b, required 1", o_cready[0]); end
    else exp_q.push_back('{port: 0, data: rdata(8'h34)});
    step();
    c_valid[0] = 1'b0;
    wait_drain("full");
  endtask

  task automatic test_backpressure();
    for (int p = 0; p < PORTS; p++) deliv[p] = 0;
    ram_resp_en = 1'b0;
    step();
    c_valid[1] = 1'b1;
    c_addr[1] = 8'h50;
    @(negedge clk);
    checks++;
    if (o_cready[1] !== 1'b1) begin errors++; $display("FAIL bp_cmd1: got %b, required 1", o_cready[1]); end
    else exp_q.push_back('{port: 1, data: rdata(8'h50)});
    step();
    c_valid[1] = 1'b0;
    c_valid[0] = 1'b1;
    c_addr[0] = 8'h60;
    @(negedge clk);
    checks++;
    if (o_cready[0] !== 1'b1) begin errors++; $display("FAIL bp_cmd0: got %b, required 1", o_cready[0]); end
    else exp_q.push_back('{port: 0, data: rdata(8'h60)});
    step();
    c_valid[0] = 1'b0;
    c_rready[1] = 1'b0;
    step();
    ram_resp_en = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checks += 3;
      if (ram.resp_ready[0] !== 1'b0) begin errors++; $display("FAIL bp_ram_ready%0d: got %b, required 0", j, ram.resp_ready[0]); end
      if (o_rvalid[1] !== 1'b1) begin errors++; $display("FAIL bp_valid1_%0d: got %b, required 1", j, o_rvalid[1]); end
      if (o_rvalid[0] !== 1'b0) begin errors++; $display("FAIL bp_valid0_%0d: got %b, required 0", j, o_rvalid[0]); end
      step();
    end
    c_rready[1] = 1'b1;
    wait_drain("bp");
    checks++;
    if (deliv[0] != 1 || deliv[1] != 1) begin
      errors++;
      $display("FAIL bp_deliv: got %0d/%0d, required 1/1", deliv[0], deliv[1]);
    end
  endtask

  task automatic test_async_reset();
    ram_resp_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      c_valid[0] = 1'b1;
      c_addr[0] = AW'(8'h70 + k);
    end
    step();
    c_valid[0] = 1'b0;
    step();
    ram_cready = 1'b0;
    ram_resp_en = 1'b1;
    c_valid[1] = 1'b1;
    c_addr[1] = 8'h7F;
    #1;
    checks += 2;
    if (o_cready[1] !== 1'b1) begin errors++; $display("FAIL arst_pre_cmd_ready: got %b, required 1", o_cready[1]); end
    if (o_rvalid[0] !== 1'b1) begin errors++; $display("FAIL arst_pre_resp_valid: got %b, required 1", o_rvalid[0]); end
    #1;
    rst = 1'b1;
    #1;
    checks += 2;
    if (ram.cmd_valid[0] !== 1'b0) begin errors++; $display("FAIL arst_ram_cmd_valid: got %b, required 0", ram.cmd_valid[0]); end
    if (ram.resp_ready[0] !== 1'b0) begin errors++; $display("FAIL arst_ram_resp_ready: got %b, required 0", ram.resp_ready[0]); end
    for (int p = 0; p < PORTS; p++) begin
      checks += 2;
      if (o_cready[p] !== 1'b0) begin errors++; $display("FAIL arst_cmd_ready%0d: got %b, required 0", p, o_cready[p]); end
      if (o_rvalid[p] !== 1'b0) begin errors++; $display("FAIL arst_resp_valid%0d: got %b, required 0", p, o_rvalid[p]); end
    end
    exp_q.delete();
    pend_q.delete();
    pend_cnt = 0;
    c_valid[1] = 1'b0;
    ram_cready = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    c_valid[0] = 1'b1;
    c_addr[0] = 8'h11;
    @(negedge clk);
    checks++;
    if (o_cready[0] !== 1'b1) begin errors++; $display("FAIL arst_after_cmd: got %b, required 1", o_cready[0]); end
    else exp_q.push_back('{port: 0, data: rdata(8'h11)});
    step();
    c_valid[0] = 1'b0;
    wait_drain("arst");
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_in_order();
    test_fifo_full();
    test_backpressure();
    test_async_reset();
    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
